generation_scheduler: RTL

Sequences one Game-of-Life generation at a time through the line buffer and parallel next-state pipeline. It drives `calc_flag`/`calc_row` row by row, advancing on the pipeline's row-commit pulse. It owns ping-pong BRAM bank selection, and swaps banks only at a display frame boundary so the HDMI output never tears. It sits in the top level between the user controls (run/step), the video timing (frame end) and the line buffer.

---
 rtl/generation_scheduler.sv | 125 ++++++++++++
 1 files changed

// File: rtl/generation_scheduler.sv
// ============================================================================
// Module   : generation_scheduler
// Purpose  : Steps one Game-of-Life generation row by row through the line
//            buffer, then swaps ping-pong banks on the next frame boundary.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module generation_scheduler #(
    parameter int ROWS  = 720,
    parameter int ROW_W = 10,
    parameter int GEN_W = 16
) (
    input  logic             out_stream_aclk,
    input  logic             periph_resetn,
    input  logic             run,
    input  logic             step,
    input  logic             clear,
    input  logic             frame_done,
    input  logic             row_valid,
    output logic             calc_flag,
    output logic [ROW_W-1:0] calc_row,
    output logic             read_bank,
    output logic             write_bank,
    output logic             busy,
    output logic             gen_done,
    output logic [GEN_W-1:0] gen_count
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CALC      = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } state_t;

    localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(ROWS - 1);

    state_t             state_q,     state_d;
    logic               calc_flag_q, calc_flag_d;
    logic [ROW_W-1:0]   calc_row_q,  calc_row_d;
    logic               read_bank_q, read_bank_d;
    logic               gen_done_q,  gen_done_d;
    logic [GEN_W-1:0]   gen_count_q, gen_count_d;

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_q     <= ST_IDLE;
            calc_flag_q <= 1'b0;
            calc_row_q  <= '0;
            read_bank_q <= 1'b0;
            gen_done_q  <= 1'b0;
            gen_count_q <= '0;
        end else begin
            state_q     <= state_d;
            calc_flag_q <= calc_flag_d;
            calc_row_q  <= calc_row_d;
            read_bank_q <= read_bank_d;
            gen_done_q  <= gen_done_d;
            gen_count_q <= gen_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        calc_flag_d = calc_flag_q;
        calc_row_d  = calc_row_q;
        read_bank_d = read_bank_q;
        gen_done_d  = 1'b0;
        gen_count_d = gen_count_q;

        if (clear) begin
            state_d     = ST_IDLE;
            calc_flag_d = 1'b0;
            calc_row_d  = '0;
            read_bank_d = 1'b0;
            gen_count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run || step) begin
                        state_d     = ST_CALC;
                        calc_flag_d = 1'b1;
                        calc_row_d  = '0;
                    end
                end
                ST_CALC: begin
                    if (row_valid) begin
                        if (calc_row_q == C_LAST_ROW) begin
                            state_d     = ST_WAIT_SWAP;
                            calc_flag_d = 1'b0;
                            calc_row_d  = '0;
                        end else begin
                            calc_row_d = calc_row_q + 1'b1;
                        end
                    end
                end
                ST_WAIT_SWAP: begin
                    // Swapping only here keeps the display bank stable mid-frame.
                    if (frame_done) begin
                        state_d     = ST_IDLE;
                        read_bank_d = ~read_bank_q;
                        gen_count_d = gen_count_q + 1'b1;
                        gen_done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    calc_flag_d = 1'b0;
                    calc_row_d  = '0;
                end
            endcase
        end
    end

    assign calc_flag  = calc_flag_q;
    assign calc_row   = calc_row_q;
    assign read_bank  = read_bank_q;
    assign write_bank = ~read_bank_q;
    assign busy       = (state_q != ST_IDLE);
    assign gen_done   = gen_done_q;
    assign gen_count  = gen_count_q;

endmodule

`default_nettype wire
